// File: rtl/ikbd_host_uart.sv
// ikbd_host_uart: host-side 8N1 serial endpoint for the IKBD MCU SCI link.
// RX: 2-flop synchroniser, mid-bit sampling FSM, first-word-fall-through FIFO.
// TX: start/8 data/stop serialiser with back-to-back acceptance on the last stop cycle.
// Optional macro IKBD_UART_BREAK_EN: adds rx_brk and a HOLD state for line breaks.
module ikbd_host_uart #(
  parameter int CLKS_PER_BIT = 256,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       mcu_clx2,
  input  logic       mcu_rst_n,
  input  logic       sci_txd,
  output logic       sci_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_ferr,
  output logic       rx_ovr
`ifdef IKBD_UART_BREAK_EN
  ,
  output logic       rx_brk
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_INC  = CW'(1);
  localparam logic [AW-1:0] PTR_INC  = AW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
`ifdef IKBD_UART_BREAK_EN
  localparam logic [2:0] RX_HOLD  = 3'd4;
`endif

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // ---------------------------------------------------------------- RX sync
  logic r_sync1;
  logic r_sync2;
  logic r_rx_prev;
  logic w_rx_line;
  logic w_rx_fall;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= sci_txd;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx_line = r_sync2;
  assign w_rx_fall = r_rx_prev & ~r_sync2;

  // ---------------------------------------------------------------- RX FSM
  logic [2:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_ferr;
  logic          r_rx_ovr;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_stop_smp;
  logic          w_rx_good;
  logic          w_rx_bad;
  logic          w_rx_drop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = ~w_empty & rx_ready;
  assign w_stop_smp = (r_rx_state == RX_STOP) && (r_rx_cnt == CNT_LAST);
  assign w_rx_good  = w_stop_smp & w_rx_line;
  assign w_rx_bad   = w_stop_smp & ~w_rx_line;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
  assign w_push     = w_rx_good & (~w_full | w_pop);
  assign w_rx_drop  = w_rx_good & w_full & ~w_pop;

`ifdef IKBD_UART_BREAK_EN
  logic r_rx_brk;
  logic w_rx_isbrk;
  assign w_rx_isbrk = w_rx_bad & (r_rx_shift == '0);
`endif

  // Receive state machine: start validation, mid-bit data sampling, stop check
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
`ifdef IKBD_UART_BREAK_EN
      r_rx_brk   <= 1'b0;
`endif
    end else begin
      r_rx_ferr <= 1'b0;
      r_rx_ovr  <= w_rx_drop;
`ifdef IKBD_UART_BREAK_EN
      r_rx_brk  <= 1'b0;
`endif
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == CNT_HALF) begin
            r_rx_cnt <= '0;
            if (!w_rx_line) begin
              r_rx_bit   <= '0;
              r_rx_state <= RX_DATA;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_INC;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_INC;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt <= '0;
`ifdef IKBD_UART_BREAK_EN
            if (w_rx_isbrk) begin
              r_rx_brk   <= 1'b1;
              r_rx_state <= RX_HOLD;
            end else begin
              r_rx_ferr  <= w_rx_bad;
              r_rx_state <= RX_IDLE;
            end
`else
            r_rx_ferr  <= w_rx_bad;
            r_rx_state <= RX_IDLE;
`endif
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_INC;
          end
        end
`ifdef IKBD_UART_BREAK_EN
        RX_HOLD: begin
          // Counts consecutive high cycles; any low restarts the bit-long wait
          if (!w_rx_line) begin
            r_rx_cnt <= '0;
          end else if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_INC;
          end
        end
`endif
        default: begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_ferr = r_rx_ferr;
  assign rx_ovr  = r_rx_ovr;
`ifdef IKBD_UART_BREAK_EN
  assign rx_brk  = r_rx_brk;
`endif

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0] r_mem [FIFO_DEPTH];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge mcu_clx2) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_rx_shift;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_INC;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_INC;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_valid = ~w_empty;
  assign rx_data  = w_empty ? '0 : r_mem[r_rd_ptr];

  // ---------------------------------------------------------------- TX FSM
  logic [1:0]    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_txd;
  logic          r_tx_ready;
  logic          w_tx_accept;

  assign w_tx_accept = tx_valid & r_tx_ready;

  // Transmit state machine; ready rises one cycle early so the next byte
  // is accepted on the final stop cycle and its start bit follows at once
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_accept) begin
            r_tx_shift <= tx_data;
            r_txd      <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_INC;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_INC;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == CNT_PRE) begin
            r_tx_ready <= 1'b1;
            r_tx_cnt   <= r_tx_cnt + CNT_INC;
          end else if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_accept) begin
              r_tx_shift <= tx_data;
              r_txd      <= 1'b0;
              r_tx_ready <= 1'b0;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_INC;
          end
        end
        default: begin
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign sci_rxd  = r_txd;
  assign tx_ready = r_tx_ready;

endmodule
